// File: rtl/fifo_ptr_pkg.sv
// Shared helpers for Gray-coded FIFO pointer crossings, used by both the
// launching (encode) side and the receiving (decode) side.
package fifo_ptr_pkg;

  localparam int unsigned DEF_SIZE        = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned PTR_MAX_W       = 32;

  // Operates at the widest supported width; narrower pointers are zero-extended,
  // which leaves the decoded low bits unchanged.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_rx_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned SIZE = DEF_SIZE
) (
  input  logic [SIZE-1:0] i_gray,
  output logic [SIZE-1:0] o_bin
);

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[SIZE-1:i];
  end

endmodule

// File: rtl/gray_ptr_sync_rx.sv
// Receive side of a Gray pointer crossing: synchronize, decode, and derive
// fill level, empty/full and integrity flags against the local pointer.
module gray_ptr_sync_rx
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned SIZE        = DEF_SIZE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [SIZE-1:0] i_gray_in,
  input  logic [SIZE-1:0] i_local_bin,
  output logic [SIZE-1:0] o_bin_out,
  output logic            o_bin_valid,
  output logic            o_ptr_changed,
  output logic [SIZE-1:0] o_level,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_gray_err,
  output logic            o_level_err
);

  localparam int unsigned CNT_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SIZE-1:0] HALF = {1'b1, {(SIZE-1){1'b0}}};

  logic [SYNC_STAGES-1:0][SIZE-1:0] r_sync;
  logic [SIZE-1:0]                  r_prev;
  logic [CNT_W-1:0]                 r_fill;
  logic [SIZE-1:0]                  r_bin;
  logic [SIZE-1:0]                  r_level;
  logic                             r_empty;
  logic                             r_full;
  logic                             r_level_err;
  logic                             r_ptr_changed;
  logic                             r_gray_err;

  logic [SIZE-1:0] w_sync_q;
  logic [SIZE-1:0] w_bin;
  logic [SIZE-1:0] w_level;
  logic            w_valid;
  logic            w_multi_bit;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  gray_to_bin #(
    .SIZE (SIZE)
  ) u_gray_to_bin (
    .i_gray (w_sync_q),
    .o_bin  (w_bin)
  );

  // Unsigned subtraction wraps naturally; the MSB separates full from empty.
  assign w_level     = w_bin - i_local_bin;
  assign w_valid     = (r_fill == CNT_W'(CNT_MAX));
  assign w_multi_bit = popcount(PTR_MAX_W'(w_sync_q ^ r_prev)) > 1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync        <= '0;
      r_prev        <= '0;
      r_fill        <= '0;
      r_bin         <= '0;
      r_level       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_level_err   <= 1'b0;
      r_ptr_changed <= 1'b0;
      r_gray_err    <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], i_gray_in};
      r_prev        <= w_sync_q;
      if (!w_valid) begin
        r_fill <= r_fill + 1'b1;
      end
      r_bin         <= w_bin;
      r_level       <= w_level;
      r_empty       <= (w_level == '0);
      r_full        <= (w_level == HALF);
      r_level_err   <= (w_level > HALF);
      // Change/error pulses stay quiet until the pipeline holds real samples.
      r_ptr_changed <= w_valid && (w_bin != r_bin);
      r_gray_err    <= w_valid && w_multi_bit;
    end
  end

  assign o_bin_out     = r_bin;
  assign o_bin_valid   = w_valid;
  assign o_ptr_changed = r_ptr_changed;
  assign o_level       = r_level;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_gray_err    = r_gray_err;
  assign o_level_err   = r_level_err;

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Self-checking bench for gray_ptr_sync_rx at SIZE=4, SYNC_STAGES=2: table
// vectors, hand-written corner sequences and a randomized run against a model.
module tb_gray_ptr_sync_rx;

  localparam int SIZE = 4;
  localparam int SS   = 2;
  localparam int MASK = (1 << SIZE) - 1;
  localparam int HALF = 1 << (SIZE - 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] gray_in = '0;
  logic [SIZE-1:0] local_bin = '0;
  logic [SIZE-1:0] bin_out;
  logic            bin_valid;
  logic            ptr_changed;
  logic [SIZE-1:0] level;
  logic            empty;
  logic            full;
  logic            gray_err;
  logic            level_err;

  gray_ptr_sync_rx #(
    .SIZE        (SIZE),
    .SYNC_STAGES (SS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_gray_in     (gray_in),
    .i_local_bin   (local_bin),
    .o_bin_out     (bin_out),
    .o_bin_valid   (bin_valid),
    .o_ptr_changed (ptr_changed),
    .o_level       (level),
    .o_empty       (empty),
    .o_full        (full),
    .o_gray_err    (gray_err),
    .o_level_err   (level_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: gray samples seen since reset release, indexed by edge number.
  int g_hist[$];
  int n = 0;
  int prev_bin = 0;
  int lcur = 0;

  typedef struct {
    int gray;
    int loc;
    int bin;
    int lvl;
    int emp;
    int ful;
    int lerr;
  } vec_t;

  vec_t vecs[7];

  function automatic int m_dec(int g);
    int b = 0;
    for (int s = 0; s < SIZE; s++) b ^= g >> s;
    return b & MASK;
  endfunction

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic int g_at(int j);
    if (j >= 1 && j <= n) return g_hist[j-1];
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input int exp);
    total++;
    if (act !== 16'(exp)) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input int g, input int l);
    rst_n     = r;
    gray_in   = SIZE'(g);
    local_bin = SIZE'(l);
  endtask

  // One clock edge, then compare every output with the model.
  task automatic tick();
    int e_bin, e_lvl;
    bit was_valid;
    @(posedge clk);
    if (!rst_n) begin
      g_hist.delete();
      n = 0;
    end else begin
      g_hist.push_back(int'(gray_in));
      n++;
    end
    lcur = int'(local_bin);
    #1;
    e_bin     = m_dec(g_at(n - SS));
    e_lvl     = (n == 0) ? 0 : ((e_bin - lcur) & MASK);
    was_valid = (n >= SS + 2);
    chk("model.bin_out", bin_out, e_bin);
    chk("model.bin_valid", bin_valid, int'(n >= SS + 1));
    chk("model.ptr_changed", ptr_changed, int'(was_valid && e_bin != prev_bin));
    chk("model.gray_err", gray_err,
        int'(was_valid && $countones(g_at(n - SS) ^ g_at(n - SS - 1)) > 1));
    chk("model.level", level, e_lvl);
    chk("model.empty", empty, int'(e_lvl == 0));
    chk("model.full", full, int'(e_lvl == HALF));
    chk("model.level_err", level_err, int'(e_lvl > HALF));
    prev_bin = e_bin;
  endtask

  initial begin
    int p, l;
    vecs[0] = '{gray: 'b0000, loc: 0,  bin: 0,  lvl: 0,  emp: 1, ful: 0, lerr: 0};
    vecs[1] = '{gray: 'b1010, loc: 2,  bin: 12, lvl: 10, emp: 0, ful: 0, lerr: 1};
    vecs[2] = '{gray: 'b1100, loc: 0,  bin: 8,  lvl: 8,  emp: 0, ful: 1, lerr: 0};
    vecs[3] = '{gray: 'b0101, loc: 9,  bin: 6,  lvl: 13, emp: 0, ful: 0, lerr: 1};
    vecs[4] = '{gray: 'b1000, loc: 15, bin: 15, lvl: 0,  emp: 1, ful: 0, lerr: 0};
    vecs[5] = '{gray: 'b0111, loc: 14, bin: 5,  lvl: 7,  emp: 0, ful: 0, lerr: 0};
    vecs[6] = '{gray: 'b1011, loc: 5,  bin: 13, lvl: 8,  emp: 0, ful: 1, lerr: 0};

    // Reset held with a non-zero pointer on the input.
    drive(0, 'b1111, 0);
    repeat (3) begin
      tick();
      chk("rst.bin_out", bin_out, 0);
      chk("rst.empty", empty, 1);
      chk("rst.bin_valid", bin_valid, 0);
    end
    drive(1, 'b1111, 0);
    tick();
    chk("rel1.bin_valid", bin_valid, 0);
    tick();
    chk("rel2.bin_valid", bin_valid, 0);
    tick();
    chk("rel3.bin_valid", bin_valid, 1);
    chk("rel3.bin_out", bin_out, 10);
    chk("rel3.ptr_changed", ptr_changed, 0);

    // Settled-state table.
    foreach (vecs[i]) begin
      drive(1, vecs[i].gray, vecs[i].loc);
      repeat (4) tick();
      chk("vec.bin_out", bin_out, vecs[i].bin);
      chk("vec.level", level, vecs[i].lvl);
      chk("vec.empty", empty, vecs[i].emp);
      chk("vec.full", full, vecs[i].ful);
      chk("vec.level_err", level_err, vecs[i].lerr);
      chk("vec.ptr_changed", ptr_changed, 0);
    end

    // Latency of a single-step change.
    drive(1, 'b0000, 0);
    repeat (4) tick();
    drive(1, 'b0001, 0);
    tick();
    tick();
    chk("lat.early_bin", bin_out, 0);
    tick();
    chk("lat.bin_out", bin_out, 1);
    chk("lat.level", level, 1);
    chk("lat.empty", empty, 0);
    chk("lat.ptr_changed", ptr_changed, 1);
    tick();
    chk("lat.pulse_end", ptr_changed, 0);

    // Two-bit Gray jump.
    drive(1, 'b0000, 0);
    repeat (4) tick();
    drive(1, 'b0011, 0);
    tick();
    tick();
    chk("gviol.early", gray_err, 0);
    tick();
    chk("gviol.gray_err", gray_err, 1);
    chk("gviol.bin_out", bin_out, 2);
    chk("gviol.ptr_changed", ptr_changed, 1);
    tick();
    chk("gviol.pulse_end", gray_err, 0);

    // Full wrap with the local pointer trailing by half the range.
    drive(1, 0, HALF);
    repeat (4) tick();
    chk("wrap.full_start", full, 1);
    for (int t = 1; t <= 18; t++) begin
      p = (t > 16) ? 16 : t;
      l = (t - 2 < 0) ? 0 : ((t - 2 > 16) ? 16 : t - 2);
      drive(1, to_gray(p & MASK), (l - HALF) & MASK);
      tick();
      chk("wrap.full", full, 1);
      chk("wrap.gray_err", gray_err, 0);
      chk("wrap.bin_out", bin_out, l & MASK);
    end

    // Single-cycle reset in the middle of traffic.
    drive(1, to_gray(5), 5);
    repeat (4) tick();
    chk("mid.bin_before", bin_out, 5);
    drive(0, to_gray(5), 5);
    tick();
    chk("mid.bin_rst", bin_out, 0);
    chk("mid.valid_rst", bin_valid, 0);
    drive(1, to_gray(5), 5);
    repeat (2) begin
      tick();
      chk("mid.bin_fill", bin_out, 0);
      chk("mid.pc_fill", ptr_changed, 0);
    end
    tick();
    chk("mid.bin_back", bin_out, 5);
    chk("mid.valid_back", bin_valid, 1);
    chk("mid.pc_back", ptr_changed, 0);

    // Randomized traffic: mostly legal Gray steps, some jumps and resets.
    p = 5;
    l = 5;
    for (int k = 0; k < 400; k++) begin
      int r, g;
      r = int'($urandom_range(0, 99));
      if (r < 45) p = (p + 1) & MASK;
      else if (r < 52) p = int'($urandom_range(0, MASK));
      g = to_gray(p);
      if (r >= 52 && r < 56) g = int'($urandom_range(0, MASK));
      if ($urandom_range(0, 3) == 0) l = int'($urandom_range(0, MASK));
      else if ($urandom_range(0, 1) == 0) l = (l + 1) & MASK;
      drive(r >= 97 ? 1'b0 : 1'b1, g, l);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
